// File: rtl/word_pack_sched.sv
// Round-robin scheduler sharing one byte-to-word shift packer between two byte requesters.
// Define WORD_PACK_SCHED_TIMEOUT_EN to compile in the idle timeout / abort logic.
`timescale 1ns/1ps
module word_pack_sched #(
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic [7:0]  sh_in,
  output logic        sh_en,
  output logic        sh_rst,
  input  logic [31:0] sh_word,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic        word_src,
  input  logic        word_ready,
  output logic        abort_err
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_OUT} state_t;

  state_t      state;
  logic        grant;
  logic        last_grant;
  logic [1:0]  byte_cnt;
  logic        grant_valid;
  logic [7:0]  grant_data;
  logic        fill_byte;
  logic        word_take;
  logic        abort_now;

  assign grant_valid = grant ? req1_valid : req0_valid;
  assign grant_data  = grant ? req1_data  : req0_data;
  assign fill_byte   = (state == S_FILL) && grant_valid;
  assign word_take   = (state == S_OUT) && word_ready;

`ifdef WORD_PACK_SCHED_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(IDLE_TIMEOUT - 1);
  logic [7:0] idle_cnt;
  assign abort_now = (state == S_FILL) && !grant_valid && (idle_cnt == TIMEOUT_LAST);
`else
  assign abort_now = 1'b0;
`endif

  assign req0_ready = (state == S_FILL) && !grant;
  assign req1_ready = (state == S_FILL) && grant;
  assign sh_in      = (state == S_FILL) ? grant_data : 8'h00;
  assign sh_en      = fill_byte;
  // The packer is held in clear for the whole of reset as well as on each word release.
  assign sh_rst     = rst | word_take | abort_now;
  assign word_valid = (state == S_OUT);
  assign word_data  = (state == S_OUT) ? sh_word : 32'h0;
  assign word_src   = (state == S_OUT) ? grant : 1'b0;
  assign abort_err  = abort_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      byte_cnt   <= 2'd0;
`ifdef WORD_PACK_SCHED_TIMEOUT_EN
      idle_cnt   <= 8'd0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req0_valid || req1_valid) begin
            if (req0_valid && req1_valid) grant <= ~last_grant;
            else                          grant <= req1_valid;
            state    <= S_FILL;
            byte_cnt <= 2'd0;
`ifdef WORD_PACK_SCHED_TIMEOUT_EN
            idle_cnt <= 8'd0;
`endif
          end
        end
        S_FILL: begin
          if (fill_byte) begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef WORD_PACK_SCHED_TIMEOUT_EN
            idle_cnt <= 8'd0;
`endif
            if (byte_cnt == 2'd3) state <= S_OUT;
          end else begin
`ifdef WORD_PACK_SCHED_TIMEOUT_EN
            // A byte on the expiry cycle wins, so the abort only fires on an empty cycle.
            if (abort_now) begin
              last_grant <= grant;
              state      <= S_IDLE;
            end else begin
              idle_cnt <= idle_cnt + 8'd1;
            end
`endif
          end
        end
        S_OUT: begin
          if (word_take) begin
            last_grant <= grant;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_pack_sched.sv
// Self-checking bench for word_pack_sched; models the shift packer and checks table rows plus corner sequences.
`timescale 1ns/1ps
module tb_word_pack_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [7:0]  sh_in;
  logic        sh_en, sh_rst;
  logic [31:0] sh_word;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_src;
  logic        word_ready;
  logic        abort_err;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic        r0v;
    logic [7:0]  r0d;
    logic        r1v;
    logic [7:0]  r1d;
    logic        e_r0rdy;
    logic        e_r1rdy;
    logic        e_shen;
    logic [7:0]  e_shin;
    logic        e_wv;
    logic [31:0] e_wd;
    logic        e_src;
    logic        e_shrst;
  } vec_t;

  vec_t vecs[25];

  word_pack_sched #(.IDLE_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .sh_in      (sh_in),
    .sh_en      (sh_en),
    .sh_rst     (sh_rst),
    .sh_word    (sh_word),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_src   (word_src),
    .word_ready (word_ready),
    .abort_err  (abort_err)
  );

  always #5 clk = ~clk;

  // Reference packer: first byte ends up in [7:0] after four shifts.
  always @(posedge clk) begin
    if (sh_rst)     sh_word <= 32'h0;
    else if (sh_en) sh_word <= {sh_in, sh_word[31:8]};
  end

  function automatic vec_t mk(input logic r0v, input logic [7:0] r0d, input logic r1v,
                              input logic [7:0] r1d, input logic r0rdy, input logic r1rdy,
                              input logic shen, input logic [7:0] shin, input logic wv,
                              input logic [31:0] wd, input logic src, input logic shrst);
    vec_t v;
    v.r0v = r0v; v.r0d = r0d; v.r1v = r1v; v.r1d = r1d;
    v.e_r0rdy = r0rdy; v.e_r1rdy = r1rdy; v.e_shen = shen; v.e_shin = shin;
    v.e_wv = wv; v.e_wd = wd; v.e_src = src; v.e_shrst = shrst;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req0_valid = v.r0v;
    req0_data  = v.r0d;
    req1_valid = v.r1v;
    req1_data  = v.r1d;
  endtask

  task automatic runRows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("row%0d req0_ready", i), 32'(req0_ready), 32'(vecs[i].e_r0rdy));
      checkOutput($sformatf("row%0d req1_ready", i), 32'(req1_ready), 32'(vecs[i].e_r1rdy));
      checkOutput($sformatf("row%0d sh_en", i),      32'(sh_en),      32'(vecs[i].e_shen));
      checkOutput($sformatf("row%0d sh_in", i),      32'(sh_in),      32'(vecs[i].e_shin));
      checkOutput($sformatf("row%0d word_valid", i), 32'(word_valid), 32'(vecs[i].e_wv));
      checkOutput($sformatf("row%0d word_data", i),  word_data,       vecs[i].e_wd);
      checkOutput($sformatf("row%0d word_src", i),   32'(word_src),   32'(vecs[i].e_src));
      checkOutput($sformatf("row%0d sh_rst", i),     32'(sh_rst),     32'(vecs[i].e_shrst));
      checkOutput($sformatf("row%0d abort_err", i),  32'(abort_err),  32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    word_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Offers one byte and waits (bounded) until it is accepted.
  task automatic sendByte(input logic which, input logic [7:0] d);
    logic got;
    got = 1'b0;
    if (which) begin req1_valid = 1'b1; req1_data = d; end
    else       begin req0_valid = 1'b1; req0_data = d; end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = which ? req1_ready : req0_ready;
      @(posedge clk);
      #1;
    end
    if (which) req1_valid = 1'b0;
    else       req0_valid = 1'b0;
    checkOutput($sformatf("byte %h accepted", d), 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    word_ready = 1'b1;

    vecs[0] = mk(1, 8'h11, 0, 8'h00, 0, 0, 0, 8'h00, 0, 32'h0, 0, 0);
    vecs[1] = mk(1, 8'h11, 0, 8'h00, 1, 0, 1, 8'h11, 0, 32'h0, 0, 0);
    vecs[2] = mk(1, 8'h22, 0, 8'h00, 1, 0, 1, 8'h22, 0, 32'h0, 0, 0);
    vecs[3] = mk(1, 8'h33, 0, 8'h00, 1, 0, 1, 8'h33, 0, 32'h0, 0, 0);
    vecs[4] = mk(1, 8'h44, 0, 8'h00, 1, 0, 1, 8'h44, 0, 32'h0, 0, 0);
    vecs[5] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 1, 32'h44332211, 0, 1);
    vecs[6] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0, 32'h0, 0, 0);
    vecs[7] = mk(1, 8'hA0, 1, 8'hB0, 0, 0, 0, 8'h00, 0, 32'h0, 0, 0);
    for (int i = 0; i < 4; i++)
      vecs[8+i] = mk(1, 8'hA0 + 8'(i), 1, 8'hB0, 1, 0, 1, 8'hA0 + 8'(i), 0, 32'h0, 0, 0);
    vecs[12] = mk(1, 8'hA0, 1, 8'hB0, 0, 0, 0, 8'h00, 1, 32'hA3A2A1A0, 0, 1);
    vecs[13] = mk(1, 8'hA0, 1, 8'hB0, 0, 0, 0, 8'h00, 0, 32'h0, 0, 0);
    for (int i = 0; i < 4; i++)
      vecs[14+i] = mk(1, 8'hA0, 1, 8'hB0 + 8'(i), 0, 1, 1, 8'hB0 + 8'(i), 0, 32'h0, 0, 0);
    vecs[18] = mk(1, 8'hA0, 1, 8'hB0, 0, 0, 0, 8'h00, 1, 32'hB3B2B1B0, 1, 1);
    vecs[19] = mk(1, 8'hA0, 1, 8'hB0, 0, 0, 0, 8'h00, 0, 32'h0, 0, 0);
    for (int i = 0; i < 4; i++)
      vecs[20+i] = mk(1, 8'hA0 + 8'(i), 1, 8'hB0, 1, 0, 1, 8'hA0 + 8'(i), 0, 32'h0, 0, 0);
    vecs[24] = mk(1, 8'hA0, 1, 8'hB0, 0, 0, 0, 8'h00, 1, 32'hA3A2A1A0, 0, 1);

    #1;
    checkOutput("reset req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("reset word_valid", 32'(word_valid), 32'd0);
    checkOutput("reset word_data",  word_data,       32'h0);
    checkOutput("reset sh_en",      32'(sh_en),      32'd0);
    checkOutput("reset sh_rst",     32'(sh_rst),     32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] single word from req0");
    runRows(0, 6);
    $display("[TB] both requesters contending");
    doReset();
    runRows(7, 24);

    $display("[TB] word_ready backpressure");
    doReset();
    word_ready = 1'b0;
    sendByte(0, 8'h11); sendByte(0, 8'h22); sendByte(0, 8'h33); sendByte(0, 8'h44);
    req0_valid = 1'b1; req0_data = 8'h55;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold word_valid", 32'(word_valid), 32'd1);
      checkOutput("hold word_data",  word_data,       32'h44332211);
      checkOutput("hold req0_ready", 32'(req0_ready), 32'd0);
      checkOutput("hold sh_en",      32'(sh_en),      32'd0);
      checkOutput("hold sh_rst",     32'(sh_rst),     32'd0);
      @(posedge clk); #1;
    end
    word_ready = 1'b1;
    @(negedge clk);
    checkOutput("release sh_rst",     32'(sh_rst),     32'd1);
    checkOutput("release word_valid", 32'(word_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("after release word_valid", 32'(word_valid), 32'd0);

    $display("[TB] asynchronous reset mid-FILL");
    doReset();
    sendByte(0, 8'hDE); sendByte(0, 8'hAD); sendByte(0, 8'hBE);
    req0_valid = 1'b1; req0_data = 8'h99;
    @(negedge clk);
    checkOutput("pre-reset req0_ready", 32'(req0_ready), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("async req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("async sh_en",      32'(sh_en),      32'd0);
    checkOutput("async sh_in",      32'(sh_in),      32'd0);
    checkOutput("async word_valid", 32'(word_valid), 32'd0);
    checkOutput("async sh_rst",     32'(sh_rst),     32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0;
    sendByte(0, 8'h01); sendByte(0, 8'h02); sendByte(0, 8'h03); sendByte(0, 8'h04);
    @(negedge clk);
    checkOutput("fresh word_valid", 32'(word_valid), 32'd1);
    checkOutput("fresh word_data",  word_data,       32'h04030201);
    checkOutput("fresh word_src",   32'(word_src),   32'd0);
    @(posedge clk); #1;

`ifdef WORD_PACK_SCHED_TIMEOUT_EN
    $display("[TB] idle timeout abort");
    doReset();
    sendByte(1, 8'hC1); sendByte(1, 8'hC2);
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) begin req0_valid = 1'b1; req0_data = 8'h01; end
      @(negedge clk);
      checkOutput($sformatf("timeout k%0d abort_err", k), 32'(abort_err), 32'(k == 4));
      checkOutput($sformatf("timeout k%0d sh_rst", k),    32'(sh_rst),    32'(k == 4));
      checkOutput($sformatf("timeout k%0d word_valid", k), 32'(word_valid), 32'd0);
      @(posedge clk); #1;
    end
    req1_valid = 1'b1; req1_data = 8'hC3;
    @(negedge clk);
    checkOutput("post-abort abort_err",  32'(abort_err),  32'd0);
    checkOutput("post-abort req0_ready", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("regrant req0_ready", 32'(req0_ready), 32'd1);
    checkOutput("regrant req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req1_valid = 1'b0; req0_valid = 1'b0;
    sendByte(0, 8'h02); sendByte(0, 8'h03); sendByte(0, 8'h04);
    @(negedge clk);
    checkOutput("regrant word_data", word_data,      32'h04030201);
    checkOutput("regrant word_src",  32'(word_src), 32'd0);
    @(posedge clk); #1;
`else
    $display("[TB] long gap without timeout");
    doReset();
    sendByte(0, 8'h5A); sendByte(0, 8'h5B);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("gap abort_err",  32'(abort_err),  32'd0);
      checkOutput("gap word_valid", 32'(word_valid), 32'd0);
      @(posedge clk); #1;
    end
    sendByte(0, 8'h5C); sendByte(0, 8'h5D);
    @(negedge clk);
    checkOutput("gap word_valid final", 32'(word_valid), 32'd1);
    checkOutput("gap word_data",        word_data,       32'h5D5C5B5A);
    checkOutput("gap word_src",         32'(word_src),   32'd0);
    @(posedge clk); #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/word_pack_sched.md
# word_pack_sched

Scheduler that shares the byte-to-word shift packer between two byte-stream requesters. It grants one requester at a time under round-robin priority and drives the packer's enable, data and clear inputs for four byte shifts. It then presents the packed 32-bit word downstream with a valid/ready handshake. It sits between the byte sources and the word consumer; the packer instance sits beside it and is wired through the `sh_*` ports.

## Interface
Parameters:
- `IDLE_TIMEOUT`, default 16: consecutive byte-less FILL cycles before the word is aborted (range 1..255).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req0_valid` in 1: requester 0 offers a byte.
- `req0_data` in 8: requester 0 byte.
- `req0_ready` out 1: requester 0 byte accepted this cycle (valid & ready).
- `req1_valid`, `req1_data`, `req1_ready`: same signals for requester 1.
- `sh_in` out 8: byte to the packer.
- `sh_en` out 1: packer shift enable.
- `sh_rst` out 1: packer synchronous clear.
- `sh_word` in 32: packer output, in which the first byte lands in [7:0] after four shifts.
- `word_valid` out 1: packed word available.
- `word_data` out 32: the packed word, equal to `sh_word` while `word_valid`, else 0.
- `word_src` out 1: requester index that supplied the word.
- `word_ready` in 1: consumer accepts the word.
- `abort_err` out 1: one-cycle pulse when a partial word is discarded.

## Operation
- States: IDLE, FILL, OUT. Registers:
  - `byte_cnt` (2 bits)
  - `grant` (1 bit)
  - `last_grant` (1 bit)
  - `idle_cnt` (8 bits)
- IDLE:
  - If exactly one `reqN_valid` is high, set `grant` to N.
  - If both are high, set `grant` to `~last_grant`.
  - On either grant: go to FILL and clear `byte_cnt` and `idle_cnt`.
  - No ready is asserted in IDLE.
- FILL:
  - `req[grant]_ready` = 1; the other requester's ready = 0.
  - `sh_in` = `req[grant]_data`; `sh_en` = `req[grant]_valid`.
  - On each accepted byte: `byte_cnt`++ and `idle_cnt` cleared.
  - On the 4th accepted byte (`byte_cnt` == 3): go to OUT.
  - Cycles with no byte: `idle_cnt`++.
- OUT:
  - `word_valid` = 1 and `word_src` = `grant`; `sh_en` = 0, so the packer holds.
  - On `word_valid & word_ready`: `sh_rst` = 1 for that cycle, `last_grant` ← `grant`, go to IDLE.
- Timeout: in FILL, when `idle_cnt` reaches `IDLE_TIMEOUT` - 1 with no byte that cycle:
  - `abort_err` = 1 and `sh_rst` = 1 for that cycle.
  - `last_grant` ← `grant`; go to IDLE.
  - The partial word is discarded and never presented.
- `sh_rst` = `rst` | (clear pulse), so the packer is cleared throughout reset.
- Reset values:
  - state IDLE.
  - `grant` 0, `last_grant` 1, so requester 0 wins the first contention.
  - `byte_cnt` 0, `idle_cnt` 0.
  - All ready/valid/err outputs 0; `word_data` 0; `word_src` 0; `sh_en` 0; `sh_in` 0.

## Timing
- All outputs are decoded from registered state plus same-cycle inputs; there are no extra pipeline stages.
- Minimum word period: 1 IDLE + 4 FILL + 1 OUT = 6 cycles, with `word_ready` tied high.
- `word_data` is valid the cycle after the 4th shift edge, because the packer updates on that edge.
- Gaps in the byte stream stretch FILL. `word_ready` low holds OUT indefinitely, with `word_data` stable.
- The non-granted requester sees ready = 0 until the grant is released, even if it is valid throughout.
- A byte arriving on the timeout-expiry cycle is accepted and counted; no abort occurs.
- Asynchronous `rst` mid-FILL or mid-OUT: state is lost, outputs go to reset values immediately, and the word is neither presented nor flagged.

## Configuration
- `WORD_PACK_SCHED_TIMEOUT_EN` defined: the `idle_cnt` and abort logic are compiled in, as described.
- Macro undefined:
  - FILL waits indefinitely for bytes.
  - `idle_cnt` is absent and `abort_err` is tied to 0.
  - `IDLE_TIMEOUT` is ignored.

## Test plan
- Reset, then `req0` sends 0x11, 0x22, 0x33, 0x44 back-to-back with `word_ready`=1:
  - `word_valid` in cycle 6, `word_data`=0x44332211, `word_src`=0.
  - `sh_rst` pulses on the accept cycle.
- Both requesters are held valid continuously (`req0`: 0xA0..A3, `req1`: 0xB0..B3, repeating):
  - Words alternate src 0, 1, 0, 1: 0xA3A2A1A0 then 0xB3B2B1B0.
  - The non-granted ready stays 0 throughout.
- `word_ready` held low for 10 cycles in OUT:
  - `word_valid` and `word_data` stay stable and no byte is accepted.
  - Accepted on the cycle `word_ready` rises.
- With the macro defined and `IDLE_TIMEOUT`=4, `req1` sends 2 bytes then stops:
  - `abort_err` pulses exactly once, 4 cycles after the last byte, with `sh_rst` high that cycle.
  - The FSM goes to IDLE and the next grant goes to `req0` if it is valid.
- `rst` asserted asynchronously mid-FILL after 3 bytes:
  - All outputs go to reset values within the same cycle.
  - After release, a fresh 4-byte word packs correctly with no stale bytes.
- Macro undefined, 50-cycle gap mid-word:
  - No abort.
  - The word completes correctly once the remaining bytes arrive.
